// File: rtl/regbank_writeback.sv
// regbank_writeback
// Write-side front end for the CPU register bank. It merges two result
// sources into the bank's single write port:
//   - the in-order pipeline result (single-cycle, no backpressure), and
//   - the multi-cycle unit result (valid/ready), buffered in a small FIFO.
// It also keeps a per-register pending-write scoreboard. The REG stage
// queries it to stall on operands that are still waiting for a multi-cycle
// result.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   pipe_we/addr/data          pipeline result (wins arbitration unless addr 0)
//   mc_issue, mc_issue_addr    multi-cycle op issued; marks destination busy
//   mc_valid/ready/addr/data   multi-cycle result handshake into the FIFO
//   chk_addr_a, chk_addr_b     REG-stage operand indices to check
//   hazard                     combinational: either operand is busy
//   stall_req                  registered: FIFO head starved, hold pipe_we low
//   busy_mask                  registered scoreboard, bit i = write pending
//   we, addr_d, data_d         registered register-bank write port
module regbank_writeback #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 4,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pipe_we,
    input  logic [ADDR_W-1:0]      pipe_addr,
    input  logic [DATA_W-1:0]      pipe_data,
    input  logic                   mc_issue,
    input  logic [ADDR_W-1:0]      mc_issue_addr,
    input  logic                   mc_valid,
    output logic                   mc_ready,
    input  logic [ADDR_W-1:0]      mc_addr,
    input  logic [DATA_W-1:0]      mc_data,
    input  logic [ADDR_W-1:0]      chk_addr_a,
    input  logic [ADDR_W-1:0]      chk_addr_b,
    output logic                   hazard,
    output logic                   stall_req,
    output logic [2**ADDR_W-1:0]   busy_mask,
    output logic [ADDR_W-1:0]      addr_d,
    output logic [DATA_W-1:0]      data_d,
    output logic                   we
);

    localparam int NREG  = 2**ADDR_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    // FIFO storage and control
    entry_t              mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    // Starvation tracking
    logic [STV_W-1:0]    starve_q, starve_d;
    logic                stall_q, stall_d;

    // Scoreboard
    logic [NREG-1:0]     busy_q, busy_d;

    // Registered write port
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    entry_t              head;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                pipe_win;
    logic                head_writes;

    assign head        = mem_q[rd_ptr_q];
    assign fifo_empty  = (count_q == '0);
    // Ready depends only on the registered count, so a full FIFO cannot
    // accept in the same cycle it pops.
    assign mc_ready    = (count_q < CNT_W'(FIFO_DEPTH));
    assign push        = mc_valid && mc_ready;
    // A pipeline write to register 0 is a no-op and does not block the FIFO.
    assign pipe_win    = pipe_we && (pipe_addr != '0);
    assign pop         = !pipe_win && !fifo_empty;
    // A popped head for register 0 consumes its slot but produces no write.
    assign head_writes = pop && (head.addr != '0);

    assign hazard      = busy_q[chk_addr_a] | busy_q[chk_addr_b];
    assign stall_req   = stall_q;
    assign busy_mask   = busy_q;
    assign we          = wr_en_q;
    assign addr_d      = wr_addr_q;
    assign data_d      = wr_data_q;

    // Next-state logic for FIFO pointers, starve counter, scoreboard and
    // write port.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        starve_d  = starve_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // The counter saturates at the limit; it only needs to signal
        // "starved long enough" and must not wrap if the pipeline keeps
        // winning while stall_req is up.
        if (pop) begin
            starve_d = '0;
        end else if (!fifo_empty && pipe_win && (starve_q < STV_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STV_W'(1);
        end

        // Stall is held until the starved head finally pops.
        stall_d = (starve_q == STV_W'(STARVE_LIMIT)) && !pop;

        // Clear first, set second: a same-cycle set of the same bit wins.
        if (pop) begin
            busy_d[head.addr] = 1'b0;
        end
        if (mc_issue && (mc_issue_addr != '0)) begin
            busy_d[mc_issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (pipe_win) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pipe_addr;
            wr_data_d = pipe_data;
        end else if (head_writes) begin
            wr_en_d   = 1'b1;
            wr_addr_d = head.addr;
            wr_data_d = head.data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            stall_q   <= 1'b0;
            busy_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; emptying is done by
    // the pointers and count, and stale entries are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{addr: mc_addr, data: mc_data};
        end
    end

endmodule

// File: tb/tb_regbank_writeback.sv
// Testbench for regbank_writeback: a table of cumulative single-cycle
// vectors followed by hand-written sequences for starvation, backpressure
// and reset in the middle of operation.
module tb_regbank_writeback;

    logic        clk;
    logic        reset;
    logic        pipe_we;
    logic [3:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        mc_issue;
    logic [3:0]  mc_issue_addr;
    logic        mc_valid;
    logic        mc_ready;
    logic [3:0]  mc_addr;
    logic [31:0] mc_data;
    logic [3:0]  chk_addr_a;
    logic [3:0]  chk_addr_b;
    logic        hazard;
    logic        stall_req;
    logic [15:0] busy_mask;
    logic [3:0]  addr_d;
    logic [31:0] data_d;
    logic        we;

    int total = 0;
    int bad   = 0;

    regbank_writeback #(
        .DATA_W(32), .ADDR_W(4), .FIFO_DEPTH(2), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
        .mc_issue(mc_issue), .mc_issue_addr(mc_issue_addr),
        .mc_valid(mc_valid), .mc_ready(mc_ready),
        .mc_addr(mc_addr), .mc_data(mc_data),
        .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b),
        .hazard(hazard), .stall_req(stall_req), .busy_mask(busy_mask),
        .addr_d(addr_d), .data_d(data_d), .we(we)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    typedef struct {
        logic        pw;   logic [3:0] pa; logic [31:0] pd;
        logic        iss;  logic [3:0] ia;
        logic        mv;   logic [3:0] ma; logic [31:0] md;
        logic [3:0]  ca;   logic [3:0] cb;
        logic        ewe;  logic [3:0] ea; logic [31:0] ed;
        logic [15:0] eb;   logic erdy; logic ehz; logic est;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_we = 0; pipe_addr = 0; pipe_data = 0;
        mc_issue = 0; mc_issue_addr = 0;
        mc_valid = 0; mc_addr = 0; mc_data = 0;
        chk_addr_a = 0; chk_addr_b = 0;
    endtask

    task automatic check_port(input string tag, input logic ewe, input logic [3:0] ea,
                              input logic [31:0] ed);
        check({tag, ".we"}, 64'(we), 64'(ewe));
        check({tag, ".addr_d"}, 64'(addr_d), 64'(ea));
        check({tag, ".data_d"}, 64'(data_d), 64'(ed));
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;

        // Reset state
        check_port("reset", 0, 0, 0);
        check("reset.busy", 64'(busy_mask), 64'h0);
        check("reset.ready", 64'(mc_ready), 64'h1);
        check("reset.stall", 64'(stall_req), 64'h0);
        check("reset.hazard", 64'(hazard), 64'h0);

        // Cumulative vectors; expectations are the outputs just after the edge.
        //           pw pa  pd          iss ia  mv ma  md           ca cb  ewe ea  ed           eb       rdy hz st
        vecs[0]  = '{0, 0, 32'h0,      0, 0,  0, 0,  32'h0,       0, 0,  0, 0,  32'h0,      16'h0000, 1, 0, 0};
        vecs[1]  = '{1, 3, 32'h1234,   0, 0,  0, 0,  32'h0,       0, 0,  1, 3,  32'h1234,   16'h0000, 1, 0, 0};
        vecs[2]  = '{0, 0, 32'h0,      0, 0,  0, 0,  32'h0,       0, 0,  0, 3,  32'h1234,   16'h0000, 1, 0, 0};
        vecs[3]  = '{0, 0, 32'h0,      1, 5,  0, 0,  32'h0,       5, 0,  0, 3,  32'h1234,   16'h0020, 1, 1, 0};
        vecs[4]  = '{0, 0, 32'h0,      0, 0,  1, 5,  32'hDEAD,    5, 0,  0, 3,  32'h1234,   16'h0020, 1, 1, 0};
        vecs[5]  = '{0, 0, 32'h0,      0, 0,  0, 0,  32'h0,       5, 0,  1, 5,  32'hDEAD,   16'h0000, 1, 0, 0};
        vecs[6]  = '{1, 0, 32'hFFFF,   0, 0,  0, 0,  32'h0,       0, 0,  0, 5,  32'hDEAD,   16'h0000, 1, 0, 0};
        vecs[7]  = '{1, 9, 32'h99,     1, 0,  0, 0,  32'h0,       0, 0,  1, 9,  32'h99,     16'h0000, 1, 0, 0};
        vecs[8]  = '{0, 0, 32'h0,      1, 6,  1, 0,  32'hBEEF,    0, 0,  0, 9,  32'h99,     16'h0040, 1, 0, 0};
        vecs[9]  = '{0, 0, 32'h0,      0, 0,  0, 0,  32'h0,       0, 6,  0, 9,  32'h99,     16'h0040, 1, 1, 0};
        vecs[10] = '{0, 0, 32'h0,      0, 0,  0, 0,  32'h0,       0, 6,  0, 9,  32'h99,     16'h0040, 1, 1, 0};
        vecs[11] = '{1, 6, 32'h66,     0, 0,  0, 0,  32'h0,       0, 6,  1, 6,  32'h66,     16'h0040, 1, 1, 0};
        vecs[12] = '{0, 0, 32'h0,      0, 0,  1, 6,  32'h600D,    0, 6,  0, 6,  32'h66,     16'h0040, 1, 1, 0};
        vecs[13] = '{0, 0, 32'h0,      0, 0,  0, 0,  32'h0,       0, 6,  1, 6,  32'h600D,   16'h0000, 1, 0, 0};
        vecs[14] = '{0, 0, 32'h0,      0, 0,  1, 4,  32'h44,      0, 0,  0, 6,  32'h600D,   16'h0000, 1, 0, 0};
        vecs[15] = '{1, 0, 32'h1,      0, 0,  0, 0,  32'h0,       0, 0,  1, 4,  32'h44,     16'h0000, 1, 0, 0};

        for (int i = 0; i < 16; i++) begin
            pipe_we = vecs[i].pw; pipe_addr = vecs[i].pa; pipe_data = vecs[i].pd;
            mc_issue = vecs[i].iss; mc_issue_addr = vecs[i].ia;
            mc_valid = vecs[i].mv; mc_addr = vecs[i].ma; mc_data = vecs[i].md;
            chk_addr_a = vecs[i].ca; chk_addr_b = vecs[i].cb;
            tick();
            check_port($sformatf("vec%0d", i), vecs[i].ewe, vecs[i].ea, vecs[i].ed);
            check($sformatf("vec%0d.busy", i), 64'(busy_mask), 64'(vecs[i].eb));
            check($sformatf("vec%0d.ready", i), 64'(mc_ready), 64'(vecs[i].erdy));
            check($sformatf("vec%0d.hazard", i), 64'(hazard), 64'(vecs[i].ehz));
            check($sformatf("vec%0d.stall", i), 64'(stall_req), 64'(vecs[i].est));
        end
        idle_inputs();
        tick();

        // Starvation: head {7,AA} loses to a continuous pipeline stream.
        reset = 1; tick(); reset = 0;
        pipe_we = 1; pipe_addr = 2; pipe_data = 32'h100;
        mc_valid = 1; mc_addr = 7; mc_data = 32'hAA;
        tick();
        mc_valid = 0;
        for (int k = 1; k <= 5; k++) begin
            pipe_data = 32'h100 + 32'(k);
            tick();
            check($sformatf("starve%0d.stall", k), 64'(stall_req), 64'(k == 5));
            check_port($sformatf("starve%0d", k), 1, 2, 32'h100 + 32'(k));
        end
        pipe_we = 0;
        tick();
        check_port("starve.pop", 1, 7, 32'hAA);
        check("starve.pop.stall", 64'(stall_req), 64'h0);
        tick();
        check("starve.after.we", 64'(we), 64'h0);

        // Backpressure: two entries fill the FIFO behind pipeline traffic.
        idle_inputs();
        reset = 1; tick(); reset = 0;
        pipe_we = 1; pipe_addr = 2; pipe_data = 32'h5;
        mc_valid = 1; mc_addr = 8; mc_data = 32'h11;
        tick();
        check("bp.push1.ready", 64'(mc_ready), 64'h1);
        mc_addr = 9; mc_data = 32'h22;
        tick();
        check("bp.push2.ready", 64'(mc_ready), 64'h0);
        mc_addr = 10; mc_data = 32'h33;
        tick();
        check("bp.held.ready", 64'(mc_ready), 64'h0);
        check_port("bp.held", 1, 2, 32'h5);
        check("bp.held.stall", 64'(stall_req), 64'h0);
        pipe_we = 0;
        tick();
        check_port("bp.pop1", 1, 8, 32'h11);
        check("bp.pop1.ready", 64'(mc_ready), 64'h1);
        tick();
        check_port("bp.pop2", 1, 9, 32'h22);
        check("bp.pop2.ready", 64'(mc_ready), 64'h1);
        mc_valid = 0;
        tick();
        check_port("bp.pop3", 1, 10, 32'h33);
        tick();
        check("bp.drained.we", 64'(we), 64'h0);

        // Reset mid-operation: two buffered entries, registers 7 and 8 busy.
        idle_inputs();
        pipe_we = 1; pipe_addr = 2; pipe_data = 32'h7;
        mc_issue = 1; mc_issue_addr = 7;
        tick();
        mc_issue_addr = 8;
        mc_valid = 1; mc_addr = 7; mc_data = 32'h70;
        tick();
        mc_issue = 0;
        mc_addr = 8; mc_data = 32'h80;
        tick();
        check("mid.busy", 64'(busy_mask), 64'h0180);
        check("mid.ready", 64'(mc_ready), 64'h0);
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
        check_port("mid.reset", 0, 0, 0);
        check("mid.reset.busy", 64'(busy_mask), 64'h0);
        check("mid.reset.ready", 64'(mc_ready), 64'h1);
        check("mid.reset.stall", 64'(stall_req), 64'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("mid.after%0d.we", k), 64'(we), 64'h0);
            check($sformatf("mid.after%0d.ready", k), 64'(mc_ready), 64'h1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regbank_writeback.md
Name: regbank_writeback

Overview:
Write-side front end for the CPU register bank. It merges two result sources into the bank's single write port (`addr_d`/`data_d`/`we`):
- the in-order pipeline result (single-cycle, no backpressure);
- a multi-cycle unit result (load/divide, valid/ready handshake), buffered in a small FIFO.

It also keeps a per-register pending-write scoreboard. The REG stage queries it to stall on operands whose multi-cycle result has not yet been written.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 4, register index width (16 registers)
- FIFO_DEPTH, 2, multi-cycle result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive cycles a FIFO head may lose arbitration before stall_req asserts

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- pipe_we  in  1  pipeline result valid this cycle
- pipe_addr  in  ADDR_W  pipeline destination register
- pipe_data  in  DATA_W  pipeline result
- mc_issue  in  1  multi-cycle op issued from REG stage this cycle
- mc_issue_addr  in  ADDR_W  destination of issued multi-cycle op
- mc_valid  in  1  multi-cycle result offered
- mc_ready  out  1  buffer can accept result
- mc_addr  in  ADDR_W  multi-cycle result destination
- mc_data  in  DATA_W  multi-cycle result
- chk_addr_a  in  ADDR_W  REG-stage operand A index
- chk_addr_b  in  ADDR_W  REG-stage operand B index
- hazard  out  1  combinational: busy[chk_addr_a] or busy[chk_addr_b]
- stall_req  out  1  registered: upstream must hold pipe_we low next cycle
- busy_mask  out  16  registered scoreboard, bit i = write pending to reg i
- addr_d  out  ADDR_W  register bank write address
- data_d  out  DATA_W  register bank write data
- we  out  1  register bank write enable

Behaviour:
Reset and acceptance:
- Reset (sync, any cycle, including mid-operation): `we`, `addr_d`, `data_d`, `stall_req`, `busy_mask` = 0; FIFO emptied; starve counter = 0. Buffered results are discarded.
- `mc_ready` = FIFO count < FIFO_DEPTH, derived from the registered count only. No same-cycle pop-through.
- A push occurs on `mc_valid && mc_ready`.

Write port:
- Registered. A source selected in cycle N appears on `we`/`addr_d`/`data_d` in cycle N+1. `we` is a single-cycle pulse per write.
- Arbitration each cycle:
  - `pipe_we` with `pipe_addr`≠0 wins.
  - Otherwise the FIFO head (if non-empty) pops and writes.
  - Otherwise `we`=0; `addr_d`/`data_d` hold their last values.
- Register 0: a pipeline write to addr 0 produces no `we`. A FIFO head with addr 0 pops without `we` and consumes the slot.
- An entry pushed in cycle N is at the earliest popped in N+1, so it appears on `we` in N+2.

Starvation:
- The starve counter increments each cycle the FIFO is non-empty and loses to the pipeline, and clears on any pop.
- When counter == STARVE_LIMIT, `stall_req`=1 the next cycle. `pipe_we` is guaranteed low while `stall_req`=1, so the head pops.
- `stall_req` deasserts the cycle after that pop.
- If `pipe_we` is high while `stall_req`=1 (protocol violation), the pipeline still wins.

Scoreboard:
- `mc_issue` with `mc_issue_addr`≠0 sets `busy[mc_issue_addr]` next cycle.
- A FIFO pop of addr k clears `busy[k]` next cycle.
- Same-cycle set and clear of the same bit: set wins.
- Issuing to a register that is already busy is illegal; the REG stage prevents it via `hazard`.
- A pipeline write to a busy register does not clear the bit.
- `busy[0]` is always 0.
- `hazard` is combinational from the registered `busy_mask`. The same-cycle issue is not visible until the next cycle.

Ordering:
- FIFO order is preserved.
- The pipeline and multi-cycle unit never target the same register concurrently; this is guaranteed by the scoreboard stall.

Test Plan:
- Reset then idle: all outputs 0, `mc_ready`=1. `pipe_we`=1, addr 3, data 0x1234 → cycle+1 `we`=1, `addr_d`=3, `data_d`=0x1234; cycle+2 `we`=0.
- Scoreboard/load: `mc_issue` addr 5 → `busy_mask`=0x0020; `chk_addr_a`=5 → `hazard`=1. Push {5, 0xDEAD} with no pipe traffic → `we` for reg 5 two cycles after push, `busy_mask`=0 one cycle after pop.
- Collision: push {7, 0xAA} while `pipe_we` continuous to reg 2 → pipeline writes win. After 4 losses `stall_req`=1; bench drops `pipe_we` → reg 7 written; `stall_req`=0 the cycle after.
- Backpressure: with pipe busy, push 2 entries → `mc_ready`=0, third `mc_valid` held. On first pop `mc_ready`=1 next cycle; entries are written in order.
- Register 0: `pipe_we` addr 0 → no `we`. FIFO entry addr 0 → popped, no `we`, `busy_mask` unchanged.
- Reset mid-operation: FIFO holds 2 entries and `busy_mask`=0x0180; assert `reset` one cycle → FIFO empty, `busy_mask`=0, no subsequent `we`.
